led_matrix_scanner: RTL and testbench

- Parametrised row-scanning driver for an R×C LED matrix. Successor to the fixed 8×8 matrix decoder.
- Holds a double-buffered frame: the producer writes rows into a back bank while the front bank is scanned out one row at a time.
- Inserts a blanking gap between rows to suppress ghosting. Swaps banks only at frame boundaries, so no frame ever tears.
- Sits between the pattern/game logic and the physical row/column pins.

---
 rtl/led_matrix_pkg.sv | 28 ++
 rtl/led_frame_buffer.sv | 49 ++++
 rtl/led_matrix_scanner.sv | 142 ++++++++++++++
 tb/tb_led_matrix_scanner.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_matrix_pkg.sv
// Shared types and helpers for the LED matrix row scanner.
package led_matrix_pkg;

    // Widest row index the one-hot helper accepts (up to 32 rows).
    localparam int unsigned ROW_IDX_W = 5;
    localparam int unsigned MAX_ROWS  = 32;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } scan_state_t;

    // Width of the shared dwell/blank counter: one bit of headroom above the larger phase.
    function automatic int unsigned cnt_width(input int unsigned dwell, input int unsigned blank);
        int unsigned m;
        m = (dwell > blank) ? dwell : blank;
        return $clog2(m) + 1;
    endfunction

    // One-hot decode of a row index.
    function automatic logic [MAX_ROWS-1:0] onehot(input logic [ROW_IDX_W-1:0] idx);
        logic [MAX_ROWS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/led_frame_buffer.sv
// Double-buffered frame store: producer writes the back bank, scanner reads the front bank.
module led_frame_buffer #(
    parameter int unsigned ROWS = 8,
    parameter int unsigned COLS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [$clog2(ROWS)-1:0] wr_row,
    input  logic [COLS-1:0]         wr_data,
    input  logic                    swap,
    input  logic [$clog2(ROWS)-1:0] rd_row,
    output logic [COLS-1:0]         rd_data_c
);

    logic [COLS-1:0] bank0 [ROWS];
    logic [COLS-1:0] bank1 [ROWS];
    logic            front_sel;
    logic            wr_ok_c;

    // Rows beyond the matrix are silently dropped.
    assign wr_ok_c = wr_en && (32'(wr_row) < ROWS);

    // Bank storage and bank pointer; a write on a swap edge lands in the bank about to become front.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank0     <= '{default: '0};
            bank1     <= '{default: '0};
            front_sel <= 1'b0;
        end else begin
            if (wr_ok_c) begin
                if (front_sel) begin
                    bank0[wr_row] <= wr_data;
                end else begin
                    bank1[wr_row] <= wr_data;
                end
            end
            if (swap) begin
                front_sel <= ~front_sel;
            end
        end
    end

    // Front-bank read for the row being scanned.
    always_comb begin
        rd_data_c = front_sel ? bank1[rd_row] : bank0[rd_row];
    end

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-scanning LED matrix driver with blanking gaps and tear-free bank swaps.
module led_matrix_scanner
    import led_matrix_pkg::*;
#(
    parameter int unsigned ROWS       = 8,
    parameter int unsigned COLS       = 8,
    parameter int unsigned DWELL      = 4,
    parameter int unsigned BLANK      = 1,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    wr_en,
    input  logic [$clog2(ROWS)-1:0] wr_row,
    input  logic [COLS-1:0]         wr_data,
    input  logic                    swap_req,
    output logic                    swap_ack,
    output logic                    frame_done,
    output logic [ROWS-1:0]         row_sel,
    output logic [COLS-1:0]         col_data
);

    localparam int unsigned    RW         = $clog2(ROWS);
    localparam int unsigned    CW         = cnt_width(DWELL, BLANK);
    localparam logic [CW-1:0]  DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0]  BLANK_LAST = CW'(BLANK - 1);
    localparam logic [RW-1:0]  ROW_LAST   = RW'(ROWS - 1);
    localparam logic [ROWS-1:0] ROW_IDLE  = {ROWS{ACTIVE_LOW}};
    localparam logic [COLS-1:0] COL_IDLE  = {COLS{ACTIVE_LOW}};

    scan_state_t     state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [RW-1:0]   row, row_n;
    logic            pending, pending_n;
    logic            swap_c;
    logic            frame_done_n, swap_ack_n;
    logic [ROWS-1:0] row_sel_n;
    logic [COLS-1:0] col_data_n;
    logic [ROWS-1:0] row_hot_c;
    logic [COLS-1:0] front_row_c;

    led_frame_buffer #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_fb (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_row    (wr_row),
        .wr_data   (wr_data),
        .swap      (swap_c),
        .rd_row    (row),
        .rd_data_c (front_row_c)
    );

    // One-hot drive for the current row, before polarity.
    always_comb begin
        row_hot_c = ROWS'(onehot(ROW_IDX_W'(row)));
    end

    // Scan sequencing, swap scheduling and next output values.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        row_n        = row;
        pending_n    = pending;
        swap_c       = 1'b0;
        frame_done_n = 1'b0;
        row_sel_n    = ROW_IDLE;
        col_data_n   = COL_IDLE;

        if (!enable) begin
            state_n = ST_BLANK;
            cnt_n   = '0;
            row_n   = '0;
            swap_c  = pending;
        end else begin
            case (state)
                ST_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_n    = ST_ON;
                        cnt_n      = '0;
                        row_sel_n  = ROW_IDLE ^ row_hot_c;
                        col_data_n = COL_IDLE ^ front_row_c;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                ST_ON: begin
                    if (cnt == DWELL_LAST) begin
                        state_n = ST_BLANK;
                        cnt_n   = '0;
                        if (row == ROW_LAST) begin
                            row_n        = '0;
                            frame_done_n = 1'b1;
                            swap_c       = pending;
                        end else begin
                            row_n = row + RW'(1);
                        end
                    end else begin
                        cnt_n      = cnt + CW'(1);
                        row_sel_n  = row_sel;
                        col_data_n = col_data;
                    end
                end
                default: begin
                    state_n = ST_BLANK;
                    cnt_n   = '0;
                end
            endcase
        end

        // A request arriving on the swap edge is absorbed by that swap.
        pending_n  = swap_c ? 1'b0 : (pending | swap_req);
        swap_ack_n = swap_c;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_BLANK;
            cnt        <= '0;
            row        <= '0;
            pending    <= 1'b0;
            swap_ack   <= 1'b0;
            frame_done <= 1'b0;
            row_sel    <= ROW_IDLE;
            col_data   <= COL_IDLE;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            row        <= row_n;
            pending    <= pending_n;
            swap_ack   <= swap_ack_n;
            frame_done <= frame_done_n;
            row_sel    <= row_sel_n;
            col_data   <= col_data_n;
        end
    end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Scoreboard bench: default 8x8 instance against a time-based model, plus an active-low 4x16 instance.
module tb_led_matrix_scanner;

    localparam int RA = 8;
    localparam int DA = 4;
    localparam int BA = 1;
    localparam int PA = DA + BA;
    localparam int FA = RA * PA;

    logic clk = 1'b0;
    logic rst;

    logic       en_a, wr_en_a, swap_req_a, swap_ack_a, frame_done_a;
    logic [2:0] wr_row_a;
    logic [7:0] wr_data_a, row_sel_a, col_data_a;

    logic        en_b, wr_en_b, swap_req_b, swap_ack_b, frame_done_b;
    logic [1:0]  wr_row_b;
    logic [15:0] wr_data_b, col_data_b;
    logic [3:0]  row_sel_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    led_matrix_scanner u_a (
        .clk        (clk),
        .rst        (rst),
        .enable     (en_a),
        .wr_en      (wr_en_a),
        .wr_row     (wr_row_a),
        .wr_data    (wr_data_a),
        .swap_req   (swap_req_a),
        .swap_ack   (swap_ack_a),
        .frame_done (frame_done_a),
        .row_sel    (row_sel_a),
        .col_data   (col_data_a)
    );

    led_matrix_scanner #(
        .ROWS       (4),
        .COLS       (16),
        .DWELL      (2),
        .BLANK      (2),
        .ACTIVE_LOW (1'b1)
    ) u_b (
        .clk        (clk),
        .rst        (rst),
        .enable     (en_b),
        .wr_en      (wr_en_b),
        .wr_row     (wr_row_b),
        .wr_data    (wr_data_b),
        .swap_req   (swap_req_b),
        .swap_ack   (swap_ack_b),
        .frame_done (frame_done_b),
        .row_sel    (row_sel_b),
        .col_data   (col_data_b)
    );

    typedef struct packed {
        logic [7:0] rs;
        logic [7:0] cd;
        logic       fd;
        logic       ack;
    } obs_t;

    obs_t exp_q[$];

    // Reference model state: n = cycles elapsed since the scan (re)started.
    logic [7:0] m_bank [2][RA];
    int         m_front;
    int         m_n;
    bit         m_pend;
    logic [7:0] m_col;

    // Model: position in the scan follows from elapsed time; pushes the expected post-edge outputs.
    always @(posedge clk) begin
        obs_t e;
        int   r, o;
        bit   do_swap;
        e = '0;
        if (rst) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < RA; i++) m_bank[b][i] = 8'h00;
            m_front = 0;
            m_n     = 0;
            m_pend  = 1'b0;
            m_col   = 8'h00;
        end else begin
            do_swap = 1'b0;
            if (wr_en_a && int'(wr_row_a) < RA) m_bank[1 - m_front][wr_row_a] = wr_data_a;
            if (en_a) begin
                m_n = m_n + 1;
                r   = (m_n / PA) % RA;
                o   = m_n % PA;
                if (o == BA) m_col = m_bank[m_front][r];
                e.fd    = (m_n % FA) == 0;
                do_swap = m_pend && e.fd;
                e.rs    = (o >= BA) ? 8'(32'd1 << r) : 8'h00;
                e.cd    = (o >= BA) ? m_col : 8'h00;
            end else begin
                m_n     = 0;
                do_swap = m_pend;
            end
            if (do_swap) m_front = 1 - m_front;
            m_pend = do_swap ? 1'b0 : (m_pend | swap_req_a);
            e.ack  = do_swap;
        end
        exp_q.push_back(e);
    end

    // Monitor: compare every presented output set against the scoreboard.
    always @(negedge clk) begin
        obs_t e, g;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {row_sel_a, col_data_a, frame_done_a, swap_ack_a};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL scan_a t=%0t got rs=%h cd=%h fd=%b ack=%b exp rs=%h cd=%h fd=%b ack=%b",
                         $time, g.rs, g.cd, g.fd, g.ack, e.rs, e.cd, e.fd, e.ack);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Wait (bounded) until the model's frame position reaches target.
    task automatic wait_pos(input int target, input string name);
        int k;
        k = 0;
        while ((m_n % FA) != target && k < 200) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if ((m_n % FA) != target) begin
            errors++;
            $display("FAIL %s timeout got=%0d exp=%0d", name, m_n % FA, target);
        end
    endtask

    task automatic wait_b(input bit on_ack, output int k);
        k = 0;
        while (!(on_ack ? swap_ack_b : frame_done_b) && k < 100) begin
            @(negedge clk);
            k++;
        end
    endtask

    logic [7:0] pat [8] = '{8'h3C, 8'h3C, 8'h1C, 8'h18, 8'h18, 8'h08, 8'h08, 8'h08};

    initial begin
        int k;
        rst = 1'b1;
        en_a = 0; wr_en_a = 0; wr_row_a = '0; wr_data_a = '0; swap_req_a = 0;
        en_b = 0; wr_en_b = 0; wr_row_b = '0; wr_data_b = '0; swap_req_b = 0;
        repeat (3) @(negedge clk);
        chk("b_reset_rows", 32'(row_sel_b), 32'h0000_000F);
        chk("b_reset_cols", 32'(col_data_b), 32'h0000_FFFF);
        rst  = 1'b0;
        en_a = 1'b1;
        repeat (45) @(negedge clk);

        // Load pattern into the back bank (rows 7..0), then a merged double swap request.
        for (int i = 0; i < 8; i++) begin
            wr_en_a = 1; wr_row_a = 3'(7 - i); wr_data_a = pat[i];
            @(negedge clk);
        end
        wr_en_a = 0;
        swap_req_a = 1; @(negedge clk);
        swap_req_a = 1; @(negedge clk);
        swap_req_a = 0;
        repeat (90) @(negedge clk);

        // Write on the swap cycle lands in the new front bank.
        swap_req_a = 1; @(negedge clk); swap_req_a = 0;
        wait_pos(FA - 1, "swap_cycle_wait");
        wr_en_a = 1; wr_row_a = 3'd3; wr_data_a = 8'hFF;
        @(negedge clk);
        wr_en_a = 0;
        repeat (45) @(negedge clk);

        // Disable mid-row 5 with a swap pending.
        wait_pos(21, "row4_wait");
        swap_req_a = 1; @(negedge clk); swap_req_a = 0;
        wait_pos(27, "row5_wait");
        en_a = 0;
        wr_en_a = 1; wr_row_a = 3'd5; wr_data_a = 8'h81;
        @(negedge clk);
        wr_en_a = 0;
        chk("dis_ack", 32'(swap_ack_a), 32'd1);
        chk("dis_done", 32'(frame_done_a), 32'd0);
        chk("dis_rows", 32'(row_sel_a), 32'd0);
        repeat (2) @(negedge clk);
        en_a = 1;
        @(negedge clk);
        chk("reen_row0", 32'(row_sel_a), 32'h01);
        repeat (44) @(negedge clk);

        // Randomized traffic with an occasional mid-scan reset.
        for (int c = 0; c < 600; c++) begin
            wr_en_a    = ($urandom_range(0, 2) == 0);
            wr_row_a   = 3'($urandom);
            wr_data_a  = 8'($urandom);
            swap_req_a = ($urandom_range(0, 30) == 0);
            en_a       = ($urandom_range(0, 50) != 0);
            rst        = (c == 300);
            @(negedge clk);
        end
        rst = 0; en_a = 1; wr_en_a = 0; swap_req_a = 0;

        // Active-low instance: frame period, polarity of a lit row after a swap.
        en_b = 1;
        wait_b(1'b0, k);
        @(negedge clk);
        wait_b(1'b0, k);
        chk("b_period", 32'(k + 1), 32'd16);
        wr_en_b = 1; wr_row_b = 2'd0; wr_data_b = 16'h00A5;
        @(negedge clk);
        wr_en_b = 0; swap_req_b = 1;
        @(negedge clk);
        swap_req_b = 0;
        wait_b(1'b1, k);
        chk("b_ack_seen", 32'(swap_ack_b), 32'd1);
        chk("b_ack_with_done", 32'(frame_done_b), 32'd1);
        @(negedge clk);
        chk("b_blank_rows", 32'(row_sel_b), 32'h0000_000F);
        @(negedge clk);
        chk("b_lit_rows", 32'(row_sel_b), 32'h0000_000E);
        chk("b_lit_cols", 32'(col_data_b), 32'h0000_FF5A);

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
